// File: rtl/hilbert_mask_if.sv
// Bus for the Hilbert mask stage: spectrum in (ED/START/DReal/DImag),
// weighted spectrum out (RDY/VALID/DOReal/DOImag) plus sticky OVF.
interface hilbert_mask_if #(
  parameter int total_bits = 32
);
  logic                  ED;
  logic                  START;
  logic [total_bits-1:0] DReal;
  logic [total_bits-1:0] DImag;
  logic                  RDY;
  logic                  VALID;
  logic [total_bits-1:0] DOReal;
  logic [total_bits-1:0] DOImag;
  logic                  OVF;

  modport master (
    output ED, START, DReal, DImag,
    input  RDY, VALID, DOReal, DOImag, OVF
  );

  modport slave (
    input  ED, START, DReal, DImag,
    output RDY, VALID, DOReal, DOImag, OVF
  );
endinterface

// File: rtl/hilbert_mask.sv
// Analytic-signal weighting between forward and inverse fft32 passes.
// Bin 0 and Nyquist pass, positive bins x2, negative bins zeroed.
// Stage 1 captures the bin and its index, stage 2 weights and registers it,
// giving one ED-cycle from capture to output.
// Build option: HILB_SAT_EN -- saturate overflowing x2 bins instead of wrapping.
module hilbert_mask #(
  parameter int total_bits = 32,
  parameter int NBINS      = 32
) (
  input  logic           CLK,
  input  logic           RST,
  hilbert_mask_if.slave  bus
);
  localparam int KW   = $clog2(NBINS);
  localparam int HALF = NBINS / 2;

  typedef enum logic {IDLE, RUN} state_t;
  typedef logic [total_bits-1:0] samp_t;

  // Returns {overflow, weighted value} for one component of bin k.
  function automatic logic [total_bits:0] weigh(input samp_t x, input logic [KW-1:0] k);
    logic  ovf;
    samp_t y;
    ovf = 1'b0;
    y   = x;
    if (k == '0 || k == KW'(HALF)) begin
      y = x;
    end else if (k < KW'(HALF)) begin
      ovf = x[total_bits-1] ^ x[total_bits-2];
`ifdef HILB_SAT_EN
      if (ovf)
        y = x[total_bits-1] ? {1'b1, {(total_bits-1){1'b0}}}
                            : {1'b0, {(total_bits-1){1'b1}}};
      else
        y = {x[total_bits-2:0], 1'b0};
`else
      y = {x[total_bits-2:0], 1'b0};
`endif
    end else begin
      y = '0;
    end
    return {ovf, y};
  endfunction

  state_t        state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic          cap_vld_q, cap_vld_d;
  logic [KW-1:0] cap_k_q, cap_k_d;
  samp_t         cap_re_q, cap_re_d;
  samp_t         cap_im_q, cap_im_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  samp_t         dore_q, dore_d;
  samp_t         doim_q, doim_d;
  logic          ovf_q, ovf_d;

  logic [total_bits:0] w_re, w_im;

  // Weight the captured bin for the output stage.
  always_comb begin
    w_re = weigh(cap_re_q, cap_k_q);
    w_im = weigh(cap_im_q, cap_k_q);
  end

  // Framing FSM, capture stage and output stage; everything frozen when ED=0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_vld_d = cap_vld_q;
    cap_k_d   = cap_k_q;
    cap_re_d  = cap_re_q;
    cap_im_d  = cap_im_q;
    rdy_d     = rdy_q;
    vld_d     = vld_q;
    dore_d    = dore_q;
    doim_d    = doim_q;
    ovf_d     = ovf_q;
    if (bus.ED) begin
      // START always wins: aborts any frame in progress, including on bin 31.
      if (bus.START) begin
        state_d = RUN;
        cnt_d   = KW'(1);
      end else if (state_q == RUN) begin
        cnt_d = cnt_q + KW'(1);
        if (cnt_q == KW'(NBINS-1)) state_d = IDLE;
      end

      cap_vld_d = bus.START || (state_q == RUN);
      if (cap_vld_d) begin
        cap_k_d  = bus.START ? '0 : cnt_q;
        cap_re_d = bus.DReal;
        cap_im_d = bus.DImag;
      end

      // Outputs hold their last value outside a frame; only flags drop.
      if (cap_vld_q) begin
        vld_d  = 1'b1;
        rdy_d  = (cap_k_q == '0);
        dore_d = w_re[total_bits-1:0];
        doim_d = w_im[total_bits-1:0];
        ovf_d  = ovf_q | w_re[total_bits] | w_im[total_bits];
      end else begin
        vld_d = 1'b0;
        rdy_d = 1'b0;
      end

      // A new frame starts with a clean overflow flag.
      if (bus.START) ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_k_q   <= '0;
      cap_re_q  <= '0;
      cap_im_q  <= '0;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      dore_q    <= '0;
      doim_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_vld_q <= cap_vld_d;
      cap_k_q   <= cap_k_d;
      cap_re_q  <= cap_re_d;
      cap_im_q  <= cap_im_d;
      rdy_q     <= rdy_d;
      vld_q     <= vld_d;
      dore_q    <= dore_d;
      doim_q    <= doim_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.RDY    = rdy_q;
  assign bus.VALID  = vld_q;
  assign bus.DOReal = dore_q;
  assign bus.DOImag = doim_q;
  assign bus.OVF    = ovf_q;
endmodule

// File: tb/tb_hilbert_mask.sv
// Directed bench for hilbert_mask: impulse frame, overflow, ED gating,
// mid-frame restart, async reset, back-to-back frames.
module tb_hilbert_mask;
  logic CLK, RST;
  int   n_chk = 0;
  int   n_err = 0;

  hilbert_mask_if #(.total_bits(32)) bus ();

  hilbert_mask #(.total_bits(32), .NBINS(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic drive(input logic ed, input logic st, input logic [31:0] re, input logic [31:0] im);
    bus.ED    = ed;
    bus.START = st;
    bus.DReal = re;
    bus.DImag = im;
    @(posedge CLK);
    #1;
  endtask

  // Impulse frame (100,-50) expected output for bin k.
  function automatic int t1_re(input int k);
    if (k == 0 || k == 16) return 100;
    else if (k < 16)       return 200;
    else                   return 0;
  endfunction
  function automatic int t1_im(input int k);
    if (k == 0 || k == 16) return -50;
    else if (k < 16)       return -100;
    else                   return 0;
  endfunction

  // Ramp frame (k+1, -(k+1)) expected real output for bin k.
  function automatic int t3_re(input int k);
    if (k == 0)       return 1;
    else if (k == 16) return 17;
    else if (k < 16)  return 2 * (k + 1);
    else              return 0;
  endfunction

  logic [31:0] exp_sat;
  int nv, nr, fv, lv, j;
  logic r0, r32;

  initial begin
`ifdef HILB_SAT_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'h8000_0000;
`endif
    RST = 1'b0;
    bus.ED = 1'b0; bus.START = 1'b0; bus.DReal = '0; bus.DImag = '0;
    #12;
    chk("rst_rdy",   32'(bus.RDY),   0);
    chk("rst_valid", 32'(bus.VALID), 0);
    chk("rst_dore",  bus.DOReal,     0);
    chk("rst_doim",  bus.DOImag,     0);
    chk("rst_ovf",   32'(bus.OVF),   0);
    @(negedge CLK);
    RST = 1'b1;

    // Impulse spectrum: every bin (100,-50).
    drive(1, 1, 100, -50);
    chk("t1_pre_valid", 32'(bus.VALID), 0);
    for (int k = 1; k <= 32; k++) begin
      drive(1, 0, (k < 32) ? 32'd100 : 32'd0, (k < 32) ? -32'sd50 : 32'd0);
      chk("t1_re",    bus.DOReal,     t1_re(k-1));
      chk("t1_im",    bus.DOImag,     t1_im(k-1));
      chk("t1_valid", 32'(bus.VALID), 1);
      chk("t1_rdy",   32'(bus.RDY),   (k == 1) ? 1 : 0);
    end
    drive(1, 0, 7, 7);
    chk("t1_post_valid", 32'(bus.VALID), 0);
    chk("t1_post_hold",  bus.DOReal,     0);
    chk("t1_ovf",        32'(bus.OVF),   0);

    // x2 overflow on bin 5.
    drive(1, 1, 0, 0);
    for (int k = 1; k <= 32; k++) begin
      drive(1, 0, (k == 5) ? 32'h4000_0000 : 32'd0, 0);
      if (k == 6) begin
        chk("t2_bin5_re", bus.DOReal,   exp_sat);
        chk("t2_bin5_im", bus.DOImag,   0);
        chk("t2_ovf_set", 32'(bus.OVF), 1);
      end
    end
    chk("t2_ovf_sticky", 32'(bus.OVF), 1);

    // START reasserted at bin 20; the START also clears OVF.
    drive(1, 1, 1, 0);
    chk("t4_ovf_clr", 32'(bus.OVF), 0);
    for (int k = 1; k <= 19; k++) drive(1, 0, k + 1, 0);
    drive(1, 1, 1000, 0);
    chk("t4_bin19", bus.DOReal, 0);
    nv = 0; nr = 0;
    for (int k = 1; k <= 33; k++) begin
      drive(1, 0, 3, 0);
      if (k == 1) begin
        chk("t4_bin0_re",  bus.DOReal,   1000);
        chk("t4_bin0_rdy", 32'(bus.RDY), 1);
      end
      if (bus.VALID) nv++;
      if (bus.RDY) nr++;
    end
    chk("t4_valid_cnt", nv, 32);
    chk("t4_rdy_cnt",   nr, 1);

    // ED toggling every cycle; START/data during ED=0 must be ignored.
    nr = 0;
    for (int k = 0; k <= 32; k++) begin
      drive(1, (k == 0), (k < 32) ? k + 1 : 0, (k < 32) ? -(k + 1) : 0);
      if (k >= 1) begin
        chk("t3_re",    bus.DOReal,     t3_re(k-1));
        chk("t3_im",    bus.DOImag,     -t3_re(k-1));
        chk("t3_valid", 32'(bus.VALID), 1);
        if (bus.RDY) nr++;
      end
      drive(0, 1, 32'hDEAD_BEEF, 32'h1234_5678);
      if (k >= 1) begin
        chk("t3_hold_re",    bus.DOReal,     t3_re(k-1));
        chk("t3_hold_valid", 32'(bus.VALID), 1);
      end
    end
    chk("t3_rdy_once", nr, 1);
    drive(1, 0, 0, 0);
    chk("t3_end_valid", 32'(bus.VALID), 0);

    // Asynchronous reset in the middle of a frame.
    drive(1, 1, 9, 0);
    for (int k = 1; k <= 10; k++) drive(1, 0, 9, 0);
    chk("t5_pre_re", bus.DOReal, 18);
    #2 RST = 1'b0;
    #1;
    chk("t5_rst_re",    bus.DOReal,     0);
    chk("t5_rst_im",    bus.DOImag,     0);
    chk("t5_rst_valid", 32'(bus.VALID), 0);
    #2 RST = 1'b1;
    nv = 0;
    for (int k = 0; k < 33; k++) begin
      drive(1, 0, 9, 0);
      if (bus.VALID) nv++;
    end
    chk("t5_nostart_valid", nv, 0);
    chk("t5_nostart_re",    bus.DOReal, 0);

    // Two back-to-back frames of (5,5).
    nv = 0; nr = 0; fv = -1; lv = -1; r0 = 1'b0; r32 = 1'b0;
    for (int i = 0; i < 66; i++) begin
      drive(1, (i == 0 || i == 32), (i < 64) ? 32'd5 : 32'd0, (i < 64) ? 32'd5 : 32'd0);
      j = i - 1;
      if (bus.VALID) begin
        nv++;
        if (fv < 0) fv = j;
        lv = j;
      end
      if (bus.RDY) begin
        nr++;
        if (j == 0)  r0  = 1'b1;
        if (j == 32) r32 = 1'b1;
      end
      if (j == 33) chk("t6_f2_bin1",  bus.DOReal, 10);
      if (j == 48) chk("t6_f2_bin16", bus.DOReal, 5);
      if (j == 63) chk("t6_f2_bin31", bus.DOReal, 0);
    end
    chk("t6_valid_cnt", nv, 64);
    chk("t6_span",      lv - fv, 63);
    chk("t6_rdy_cnt",   nr, 2);
    chk("t6_rdy0",      32'(r0), 1);
    chk("t6_rdy32",     32'(r32), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
